mont_modexp_ctrl: RTL and testbench
===================================

Name: mont_modexp_ctrl

Overview:
Sequencing controller that computes Y = base^exp mod M using a left-to-right square-and-multiply schedule. It issues one modular product at a time to the existing hybrid_montgomery engine over that engine's start/done handshake. The block sits between a host (start/done request) and the single multiplier instance, and owns the operand muxing, exponent scanning and accumulator. Engine contract: on a start pulse it produces Y = A*B mod M and pulses done; inputs must satisfy A,B < M with M odd.

Parameters:
N, 32, operand/modulus width (matches engine N)
E, 32, exponent width
CW, $clog2(2*E+1), width of multiplication counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
start  in  1  host request, sampled only in IDLE
base  in  N  base operand, captured on accepted start
exp  in  E  exponent, captured on accepted start
mod_m  in  N  modulus, captured on accepted start
busy  out  1  high from accepted start until the cycle done is asserted
done  out  1  one-cycle completion pulse
err  out  1  valid with done; high if operands rejected
result  out  N  final value, held until next accepted start
mul_count  out  CW  engine operations issued for the last job
mul_start  out  1  one-cycle pulse to engine start
mul_a  out  N  engine A, stable from mul_start until mul_done
mul_b  out  N  engine B, stable likewise
mul_m  out  N  engine M = captured modulus
mul_done  in  1  engine done
mul_y  in  N  engine result, sampled on mul_done

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; busy, done, err, mul_start = 0; result, mul_count, mul_a, mul_b, mul_m, acc = 0. Reset mid-job aborts it. A late mul_done arriving after reset is ignored.
- States: IDLE, CHECK, NORM, SQR, SQR_WAIT, MUL, MUL_WAIT, FIN.
- IDLE: start=1 -> capture operands, clear mul_count, busy=1, go CHECK. Start in any other state is ignored.
- CHECK (1 cycle), in priority order:
  - mod_m==0, mod_m even, or base>=mod_m -> err=1, result=0, go FIN.
  - exp==0 -> result = (mod_m==1 ? 0 : 1), go FIN.
  - Otherwise go NORM.
- NORM: each cycle shift the exponent register left by one and decrement the bit counter until the MSB is 1 (one cycle per leading zero). When the MSB is 1:
  - acc = base; consume that bit.
  - If no bits remain, result = acc and go FIN; otherwise go SQR.
- SQR: mul_start=1, mul_a = mul_b = acc; mul_count++; go SQR_WAIT.
- SQR_WAIT: on mul_done, acc = mul_y.
  - Current bit 1 -> MUL.
  - Else, if more bits remain -> SQR; if none -> result = acc, FIN.
- MUL: mul_start=1, mul_a = acc, mul_b = base; mul_count++; go MUL_WAIT.
- MUL_WAIT: on mul_done, acc = mul_y; consume the bit; next SQR, or FIN with result = acc if no bits remain.
- FIN: done=1, busy=0 in the same cycle; go IDLE. A start in that cycle is ignored; the next accepted start is from IDLE, one cycle later.
- mul_done outside the WAIT states is ignored. mul_start is never asserted while an engine op is outstanding.
- Latency: 2 + z + sum over issued ops of (1 + L) + 1 cycles, where z = leading zeros of exp and L = engine latency (start to done).
- mul_m is driven from the captured modulus for the whole job. Operands are unsigned with no width growth; acc is N bits.

Decomposition:
- Shared package mont_pkg:
  - state enum typedef
  - N/E default localparams
  - error-code constant for the err reason (reserved for extension)
- Natural sub-module: mont_exp_scanner. It holds the exponent shift register and bit counter, and outputs cur_bit, last_bit and msb_found for NORM/consume. The FSM and operand mux stay in the top.

Test Plan:
- Behavioural engine model with fixed L=3. base=4, exp=13, mod_m=497 -> result=445, err=0, mul_count=5. done is a single-cycle pulse and busy falls in that same cycle.
- base=2, exp=10, mod_m=1023 -> result=1, mul_count=4. Check total latency = 2+28+4*4+1 = 47 cycles from start.
- exp=0, mod_m=497 -> result=1, mul_count=0. exp=0, mod_m=1 -> result=0. exp=1, base=7, mod_m=11 -> result=7, mul_count=0.
- mod_m=496 (even) -> err=1, result=0. mod_m=0 -> err=1. base=500, mod_m=497 -> err=1. All with mul_start never asserted.
- start pulsed during SQR_WAIT -> ignored, first job result unchanged (445). A spurious mul_done injected in IDLE -> no state change.
- rst=0 asserted in MUL_WAIT of the 4^13 job -> next cycle IDLE, all outputs 0; the late engine done is ignored. A fresh 4^13 job then returns 445.

Source files
------------

// File: rtl/mont_modexp_ctrl_pkg.sv
// Shared types and defaults for the Montgomery modular-exponentiation controller.
package mont_pkg;

  localparam int MONT_N = 32;
  localparam int MONT_E = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_NORM,
    S_SQR,
    S_SQR_WAIT,
    S_MUL,
    S_MUL_WAIT,
    S_FIN
  } mont_state_e;

  // Reason code behind err; only one reason exists today.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPERAND = 2'd1;

endpackage

// File: rtl/mont_modexp_ctrl_if.sv
// Host request/response bundle and multiplier-engine bundle for the modexp controller.
interface mont_host_if import mont_pkg::*; #(
  parameter int N  = MONT_N,
  parameter int E  = MONT_E,
  parameter int CW = $clog2(2*E+1)
);
  logic          start;
  logic [N-1:0]  base;
  logic [E-1:0]  exp;
  logic [N-1:0]  mod_m;
  logic          busy;
  logic          done;
  logic          err;
  logic [N-1:0]  result;
  logic [CW-1:0] mul_count;

  modport master (output start, base, exp, mod_m,
                  input  busy, done, err, result, mul_count);
  modport slave  (input  start, base, exp, mod_m,
                  output busy, done, err, result, mul_count);
endinterface

interface mont_eng_if import mont_pkg::*; #(
  parameter int N = MONT_N
);
  logic         mul_start;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [N-1:0] mul_m;
  logic         mul_done;
  logic [N-1:0] mul_y;

  modport master (output mul_start, mul_a, mul_b, mul_m,
                  input  mul_done, mul_y);
  modport slave  (input  mul_start, mul_a, mul_b, mul_m,
                  output mul_done, mul_y);
endinterface

// File: rtl/mont_modexp_ctrl_scanner.sv
// Exponent shift register and remaining-bit counter; the current bit is always the MSB.
module mont_exp_scanner import mont_pkg::*; #(
  parameter int E = MONT_E
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [E-1:0] exp_i,
  input  logic         shift_i,
  output logic         cur_bit_o,
  output logic         last_bit_o,
  output logic         msb_found_o,
  output logic         zero_o
);
  localparam int CNTW = $clog2(E+1);

  logic [E-1:0]    sr_q;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= exp_i;
      cnt_q <= CNTW'(E);
    end else if (shift_i) begin
      sr_q  <= {sr_q[E-2:0], 1'b0};
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

  assign cur_bit_o   = sr_q[E-1];
  assign msb_found_o = sr_q[E-1];
  assign last_bit_o  = (cnt_q == CNTW'(1));
  assign zero_o      = (sr_q == '0);

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier engine.
// state    | meaning
// IDLE     | waiting for host start
// CHECK    | operand validation, exp==0 shortcut
// NORM     | skip leading zeros, seed acc with base
// SQR/MUL  | issue acc*acc or acc*base to the engine
// *_WAIT   | wait for engine done, update acc
// FIN      | done pulse, busy low
module mont_modexp_ctrl import mont_pkg::*; #(
  parameter int N  = MONT_N,
  parameter int E  = MONT_E,
  parameter int CW = $clog2(2*E+1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  mont_host_if.slave  host,
  mont_eng_if.master  eng
);
  mont_state_e   state_q, state_d;
  logic [N-1:0]  base_q, base_d, mod_q, mod_d, acc_q, acc_d, result_q, result_d;
  logic          err_q, err_d;
  logic [CW-1:0] mul_count_q, mul_count_d;
  logic [1:0]    chk_code;
  logic          scan_load, scan_shift, cur_bit, last_bit, msb_found, exp_zero;

  mont_exp_scanner #(.E(E)) u_scanner (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (scan_load),
    .exp_i      (host.exp),
    .shift_i    (scan_shift),
    .cur_bit_o  (cur_bit),
    .last_bit_o (last_bit),
    .msb_found_o(msb_found),
    .zero_o     (exp_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      mod_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      mul_count_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mod_q       <= mod_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      err_q       <= err_d;
      mul_count_q <= mul_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mod_d       = mod_q;
    acc_d       = acc_q;
    result_d    = result_q;
    err_d       = err_q;
    mul_count_d = mul_count_q;
    chk_code    = ERR_NONE;
    scan_load   = 1'b0;
    scan_shift  = 1'b0;
    case (state_q)
      S_IDLE: if (host.start) begin
        base_d      = host.base;
        mod_d       = host.mod_m;
        mul_count_d = '0;
        err_d       = 1'b0;
        scan_load   = 1'b1;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (mod_q == '0 || !mod_q[0] || base_q >= mod_q) chk_code = ERR_OPERAND;
        if (chk_code != ERR_NONE) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_FIN;
        end else if (exp_zero) begin
          result_d = (mod_q == N'(1)) ? '0 : N'(1);
          state_d  = S_FIN;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        scan_shift = 1'b1;
        if (msb_found) begin
          acc_d = base_q;
          if (last_bit) begin
            result_d = base_q;
            state_d  = S_FIN;
          end else begin
            state_d = S_SQR;
          end
        end
      end
      S_SQR: begin
        mul_count_d = mul_count_q + CW'(1);
        state_d     = S_SQR_WAIT;
      end
      S_SQR_WAIT: if (eng.mul_done) begin
        acc_d = eng.mul_y;
        // A set bit keeps its place until the multiply step consumes it.
        if (cur_bit) begin
          state_d = S_MUL;
        end else begin
          scan_shift = 1'b1;
          if (last_bit) begin
            result_d = eng.mul_y;
            state_d  = S_FIN;
          end else begin
            state_d = S_SQR;
          end
        end
      end
      S_MUL: begin
        mul_count_d = mul_count_q + CW'(1);
        state_d     = S_MUL_WAIT;
      end
      S_MUL_WAIT: if (eng.mul_done) begin
        acc_d      = eng.mul_y;
        scan_shift = 1'b1;
        if (last_bit) begin
          result_d = eng.mul_y;
          state_d  = S_FIN;
        end else begin
          state_d = S_SQR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign host.busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign host.done      = (state_q == S_FIN);
  assign host.err       = err_q;
  assign host.result    = result_q;
  assign host.mul_count = mul_count_q;

  // acc only moves on mul_done, so operands hold steady for the whole engine op.
  assign eng.mul_start = (state_q == S_SQR) || (state_q == S_MUL);
  assign eng.mul_a     = acc_q;
  assign eng.mul_b     = (state_q == S_MUL || state_q == S_MUL_WAIT) ? base_q : acc_q;
  assign eng.mul_m     = mod_q;

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Scoreboard bench for mont_modexp_ctrl with a fixed-latency (L=3) behavioural engine.
module tb_mont_modexp_ctrl;
  localparam int N  = 32;
  localparam int E  = 32;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mont_host_if #(.N(N), .E(E), .CW(CW)) host ();
  mont_eng_if  #(.N(N))                 eng ();

  mont_modexp_ctrl #(.N(N), .E(E), .CW(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .host  (host),
    .eng   (eng)
  );

  // Engine model: independent of the controller reset so a late done can occur.
  logic [1:0]   eng_cnt = 2'd0;
  logic [N-1:0] eng_y   = '0;
  logic         inj_done = 1'b0;
  always @(posedge clk) begin
    if (eng.mul_start) begin
      eng_y   <= (eng.mul_m == '0) ? '0 :
                 32'((64'(eng.mul_a) * 64'(eng.mul_b)) % 64'(eng.mul_m));
      eng_cnt <= 2'd3;
    end else if (eng_cnt != 2'd0) begin
      eng_cnt <= eng_cnt - 2'd1;
    end
  end
  assign eng.mul_done = (eng_cnt == 2'd1) | inj_done;
  assign eng.mul_y    = eng_y;

  int cyc = 0;
  int ms_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng.mul_start) ms_cnt <= ms_cnt + 1;
  end

  typedef struct {
    logic [N-1:0] res;
    logic         err;
    int           cnt;
    int           lat;
    int           t0;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (eng.mul_start) check("mul_start_while_engine_busy", 64'(eng_cnt), 64'd0);
        if (host.done) begin
          done_seen++;
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 required no pending job");
          end else begin
            e = sbq.pop_front();
            check("result", 64'(host.result), 64'(e.res));
            check("err", 64'(host.err), 64'(e.err));
            check("mul_count", 64'(host.mul_count), 64'(e.cnt));
            check("busy_low_with_done", 64'(host.busy), 64'd0);
            check("done_single_pulse", 64'(prev_done), 64'd0);
            if (e.lat >= 0) check("latency", 64'(cyc - e.t0), 64'(e.lat));
          end
        end
        prev_done = host.done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic issue(input logic [N-1:0] b, input logic [E-1:0] x, input logic [N-1:0] m,
                       input logic [N-1:0] r, input logic er, input int cnt, input int lat);
    exp_t e;
    @(negedge clk);
    host.base  = b;
    host.exp   = x;
    host.mod_m = m;
    host.start = 1'b1;
    e.res = r; e.err = er; e.cnt = cnt; e.lat = lat; e.t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    host.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_seen < target; i++) @(negedge clk);
    @(negedge clk);
    check("done_within_budget", 64'(done_seen >= target), 64'd1);
  endtask

  task automatic wait_ms(input int target);
    for (int i = 0; i < 400 && ms_cnt < target; i++) @(negedge clk);
    check("mul_start_within_budget", 64'(ms_cnt >= target), 64'd1);
  endtask

  task automatic run_job(input logic [N-1:0] b, input logic [E-1:0] x, input logic [N-1:0] m,
                         input logic [N-1:0] r, input logic er, input int cnt, input int lat);
    int ms0;
    int d0;
    ms0 = ms_cnt;
    d0  = done_seen;
    issue(b, x, m, r, er, cnt, lat);
    wait_done(d0 + 1);
    check("mul_start_pulses", 64'(ms_cnt - ms0), 64'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      64'(host.busy),      64'd0);
    check({tag, "_done"},      64'(host.done),      64'd0);
    check({tag, "_err"},       64'(host.err),       64'd0);
    check({tag, "_result"},    64'(host.result),    64'd0);
    check({tag, "_mul_count"}, 64'(host.mul_count), 64'd0);
    check({tag, "_mul_start"}, 64'(eng.mul_start),  64'd0);
    check({tag, "_mul_a"},     64'(eng.mul_a),      64'd0);
    check({tag, "_mul_b"},     64'(eng.mul_b),      64'd0);
    check({tag, "_mul_m"},     64'(eng.mul_m),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int ms0;
    host.start = 1'b0;
    host.base  = '0;
    host.exp   = '0;
    host.mod_m = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // base, exp, mod, result, err, mul_count, latency
    run_job(32'd4,   32'd13, 32'd497,  32'd445, 1'b0, 5, 51);
    run_job(32'd2,   32'd10, 32'd1023, 32'd1,   1'b0, 4, 47);
    run_job(32'd3,   32'd5,  32'd7,    32'd5,   1'b0, 3, 44);
    run_job(32'd3,   32'd0,  32'd497,  32'd1,   1'b0, 0, 2);
    run_job(32'd0,   32'd0,  32'd1,    32'd0,   1'b0, 0, 2);
    run_job(32'd7,   32'd1,  32'd11,   32'd7,   1'b0, 0, 34);
    run_job(32'd3,   32'd5,  32'd496,  32'd0,   1'b1, 0, 2);
    run_job(32'd3,   32'd5,  32'd0,    32'd0,   1'b1, 0, 2);
    run_job(32'd500, 32'd5,  32'd497,  32'd0,   1'b1, 0, 2);

    // Start pulsed during SQR_WAIT must not disturb the running job.
    d0  = done_seen;
    ms0 = ms_cnt;
    issue(32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 5, 51);
    wait_ms(ms0 + 1);
    host.base  = 32'd2;
    host.exp   = 32'd10;
    host.mod_m = 32'd1023;
    host.start = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    wait_done(d0 + 1);
    repeat (80) @(negedge clk);
    check("ignored_start_no_extra_job", 64'(done_seen), 64'(d0 + 1));

    // Spurious engine done while idle.
    d0  = done_seen;
    ms0 = ms_cnt;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) @(negedge clk);
    check("spurious_done_busy", 64'(host.busy), 64'd0);
    check("spurious_done_no_done", 64'(done_seen), 64'(d0));
    check("spurious_done_no_mul", 64'(ms_cnt - ms0), 64'd0);
    check("spurious_done_result_held", 64'(host.result), 64'd445);

    run_job(32'd2, 32'd10, 32'd1023, 32'd1, 1'b0, 4, 47);

    // Reset while the MUL op of the 4^13 job is outstanding.
    d0  = done_seen;
    ms0 = ms_cnt;
    issue(32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 5, 51);
    wait_ms(ms0 + 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midjob_reset");
    sbq.delete();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("late_done_ignored_busy", 64'(host.busy), 64'd0);
    check("late_done_ignored_done", 64'(done_seen), 64'(d0));
    check("late_done_no_new_mul", 64'(ms_cnt - ms0), 64'd2);

    run_job(32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 5, 51);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
